// File: rtl/pixel_readout_seq.sv
// Pixel array readout sequencer: erase, timed exposure, then per-row select,
// settle, ADC convert, hold and deselect, finishing with a one-cycle Done.
//
// Ports:
//   Clk      - clock, all state changes on rising edge
//   Reset    - asynchronous active-high reset
//   Init     - frame start request (rising edge starts a frame from IDLE)
//   ExpTime  - exposure length in cycles, captured at frame start (0 acts as 1)
//   Abort    - synchronous frame cancel, ignored in IDLE
//   Erase    - pixel erase, high whenever no frame is in progress
//   Expose   - exposure window
//   NRE      - one-hot row read enable
//   ADC      - ADC convert strobe
//   RowIdx   - index of the row being read
//   Busy     - high in every state except IDLE
//   Done     - one-cycle frame-complete pulse
module pixel_readout_seq #(
    parameter int N_ROWS     = 2,
    parameter int EXP_W      = 5,
    parameter int SETTLE_CYC = 1,
    parameter int ADC_CYC    = 1,
    localparam int RW        = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Init,
    input  logic [EXP_W-1:0]  ExpTime,
    input  logic              Abort,
    output logic              Erase,
    output logic              Expose,
    output logic [N_ROWS-1:0] NRE,
    output logic              ADC,
    output logic [RW-1:0]     RowIdx,
    output logic              Busy,
    output logic              Done
);

    // One counter serves exposure, settle and ADC phases, so it must hold
    // both the widest ExpTime and the 4-bit cycle parameters.
    localparam int CW = (EXP_W > 4) ? EXP_W : 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXPOSE,
        S_SEL,
        S_CONV,
        S_HOLD,
        S_DESEL,
        S_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic [RW-1:0]     row_d;
    logic              init_q;
    logic              start;
    logic              cnt_last;
    logic              row_last;

    logic              erase_d;
    logic              expose_d;
    logic [N_ROWS-1:0] nre_d;
    logic              adc_d;
    logic              busy_d;
    logic              done_d;

    assign start    = Init && !init_q;
    assign cnt_last = (cnt_q == CW'(1));
    assign row_last = (RowIdx == RW'(N_ROWS - 1));

    // State, counters and registered outputs. RowIdx is itself the row
    // register, so it changes together with the state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            init_q  <= 1'b0;
            RowIdx  <= '0;
            Erase   <= 1'b1;
            Expose  <= 1'b0;
            NRE     <= '0;
            ADC     <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            init_q  <= Init;
            RowIdx  <= row_d;
            Erase   <= erase_d;
            Expose  <= expose_d;
            NRE     <= nre_d;
            ADC     <= adc_d;
            Busy    <= busy_d;
            Done    <= done_d;
        end
    end

    // Next-state logic. Abort overrides everything outside IDLE; in IDLE it
    // only suppresses a simultaneous start.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = RowIdx;
        if (Abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            row_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !Abort) begin
                        state_d = S_EXPOSE;
                        cnt_d   = (ExpTime == '0) ? CW'(1) : CW'(ExpTime);
                        row_d   = '0;
                    end
                end
                S_EXPOSE: begin
                    if (cnt_last) begin
                        state_d = S_SEL;
                        cnt_d   = CW'(SETTLE_CYC);
                        row_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_SEL: begin
                    if (cnt_last) begin
                        state_d = S_CONV;
                        cnt_d   = CW'(ADC_CYC);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_CONV: begin
                    if (cnt_last) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_HOLD: begin
                    state_d = S_DESEL;
                end
                S_DESEL: begin
                    if (row_last) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SEL;
                        cnt_d   = CW'(SETTLE_CYC);
                        row_d   = RowIdx + RW'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    row_d   = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    row_d   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so every output comes from a flop
    // yet lines up with the state it belongs to.
    always_comb begin
        erase_d  = (state_d == S_IDLE) || (state_d == S_DONE);
        expose_d = (state_d == S_EXPOSE);
        adc_d    = (state_d == S_CONV);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        nre_d    = '0;
        if (state_d == S_SEL || state_d == S_CONV || state_d == S_HOLD) begin
            nre_d = N_ROWS'(1) << row_d;
        end
    end

endmodule

// File: tb/tb_pixel_readout_seq.sv
// Scoreboard bench for pixel_readout_seq: a default instance (2 rows) and a
// 4-row instance, expected per-cycle output words built from frame timing.
module tb_pixel_readout_seq;

    // {Erase, Expose, Busy, Done, ADC, NRE[3:0], RowIdx[1:0]}
    typedef logic [10:0] word_t;
    localparam word_t IDLE_W = 11'b100_0000_0000;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;

    logic       init_a = 1'b0;
    logic       abort_a = 1'b0;
    logic [4:0] exp_a = '0;
    logic       erase_a, expose_a, adc_a, busy_a, done_a;
    logic [1:0] nre_a;
    logic [0:0] row_a;

    logic       init_b = 1'b0;
    logic       abort_b = 1'b0;
    logic [4:0] exp_b = '0;
    logic       erase_b, expose_b, adc_b, busy_b, done_b;
    logic [3:0] nre_b;
    logic [1:0] row_b;

    int passed = 0;
    int total = 0;

    word_t qa[$];
    word_t qb[$];
    word_t oa[$];
    word_t ob[$];

    always #5 Clk = ~Clk;

    pixel_readout_seq dut_a (
        .Clk(Clk), .Reset(Reset), .Init(init_a), .ExpTime(exp_a),
        .Abort(abort_a), .Erase(erase_a), .Expose(expose_a), .NRE(nre_a),
        .ADC(adc_a), .RowIdx(row_a), .Busy(busy_a), .Done(done_a)
    );

    pixel_readout_seq #(
        .N_ROWS(4), .EXP_W(5), .SETTLE_CYC(2), .ADC_CYC(3)
    ) dut_b (
        .Clk(Clk), .Reset(Reset), .Init(init_b), .ExpTime(exp_b),
        .Abort(abort_b), .Erase(erase_b), .Expose(expose_b), .NRE(nre_b),
        .ADC(adc_b), .RowIdx(row_b), .Busy(busy_b), .Done(done_b)
    );

    function automatic word_t mk(input logic er, input logic ex,
                                 input logic bu, input logic dn,
                                 input logic ad, input logic [3:0] nr,
                                 input logic [1:0] ri);
        return {er, ex, bu, dn, ad, nr, ri};
    endfunction

    function automatic word_t word_a();
        return mk(erase_a, expose_a, busy_a, done_a, adc_a,
                  {2'b00, nre_a}, {1'b0, row_a});
    endfunction

    function automatic word_t word_b();
        return mk(erase_b, expose_b, busy_b, done_b, adc_b, nre_b, row_b);
    endfunction

    // Expected frame: exposure, then per row settle/convert/hold/deselect,
    // then the Done cycle. limit >= 0 keeps only the first limit cycles.
    task automatic push_frame(input bit to_b, input int e, input int nrows,
                              input int settle, input int adcc,
                              input int limit);
        word_t f[$];
        logic [3:0] oh;
        logic [1:0] ri;
        int ee;
        int n;
        ee = (e == 0) ? 1 : e;
        for (int i = 0; i < ee; i++) f.push_back(mk(0, 1, 1, 0, 0, 4'b0, 2'b0));
        for (int r = 0; r < nrows; r++) begin
            oh = 4'b0001 << r;
            ri = 2'(r);
            for (int s = 0; s < settle; s++) f.push_back(mk(0, 0, 1, 0, 0, oh, ri));
            for (int c = 0; c < adcc; c++) f.push_back(mk(0, 0, 1, 0, 1, oh, ri));
            f.push_back(mk(0, 0, 1, 0, 0, oh, ri));
            f.push_back(mk(0, 0, 1, 0, 0, 4'b0, ri));
        end
        f.push_back(mk(1, 0, 1, 1, 0, 4'b0, 2'(nrows - 1)));
        n = (limit >= 0 && limit < f.size()) ? limit : f.size();
        for (int i = 0; i < n; i++) begin
            if (to_b) qb.push_back(f[i]);
            else qa.push_back(f[i]);
        end
    endtask

    task automatic pad_idle(input int n);
        for (int i = 0; i < n; i++) begin
            qa.push_back(IDLE_W);
            qb.push_back(IDLE_W);
        end
    endtask

    // The quiet instance is expected idle for as long as the busy one runs.
    task automatic pad();
        while (qa.size() < qb.size()) qa.push_back(IDLE_W);
        while (qb.size() < qa.size()) qb.push_back(IDLE_W);
    endtask

    task automatic cycle();
        @(negedge Clk);
        oa.push_back(word_a());
        ob.push_back(word_b());
        #1;
    endtask

    task automatic test_reset();
        word_t ea, eb, ga, gb;
        int k;
        #1 Reset = 1'b1;
        #2;
        total++;
        if (word_a() !== IDLE_W || word_b() !== IDLE_W)
            $display("FAIL reset_async a=%b b=%b expected %b", word_a(), word_b(), IDLE_W);
        else
            passed++;
        pad_idle(6);
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (i == 1) Reset = 1'b0;
        end
        k = 0;
        while (qa.size() > 0) begin
            ea = qa.pop_front(); eb = qb.pop_front();
            ga = oa.pop_front(); gb = ob.pop_front();
            total++;
            if (ga !== ea || gb !== eb)
                $display("FAIL reset cyc%0d a=%b/%b b=%b/%b (got/exp)", k, ga, ea, gb, eb);
            else
                passed++;
            k++;
        end
    endtask

    task automatic test_default();
        word_t ea, eb, ga, gb;
        int k, n, bc;
        exp_a = 5'd5;
        init_a = 1'b1;
        push_frame(0, 5, 2, 1, 1, -1);
        pad_idle(3);
        pad();
        n = qa.size();
        for (int i = 0; i < n; i++) begin
            cycle();
            if (i == 0) init_a = 1'b0;
        end
        bc = 0;
        foreach (oa[i]) bc += int'(oa[i][8]);
        total++;
        if (bc !== 14) $display("FAIL default_busy got %0d expected 14", bc);
        else passed++;
        k = 0;
        while (qa.size() > 0) begin
            ea = qa.pop_front(); eb = qb.pop_front();
            ga = oa.pop_front(); gb = ob.pop_front();
            total++;
            if (ga !== ea || gb !== eb)
                $display("FAIL default cyc%0d a=%b/%b b=%b/%b (got/exp)", k, ga, ea, gb, eb);
            else
                passed++;
            k++;
        end
    endtask

    // ExpTime=0 frame, a start attempt while busy, then a fresh frame with an
    // ExpTime that was changed during the first frame.
    task automatic test_back_to_back();
        word_t ea, eb, ga, gb;
        int k, n, bc;
        exp_a = 5'd0;
        init_a = 1'b1;
        push_frame(0, 0, 2, 1, 1, -1);
        pad_idle(2);
        push_frame(0, 3, 2, 1, 1, -1);
        pad_idle(1);
        pad();
        n = qa.size();
        for (int i = 0; i < n; i++) begin
            cycle();
            if (i == 0) begin
                init_a = 1'b0;
                exp_a = 5'd3;
            end
            if (i == 8) init_a = 1'b1;
            if (i == 10) init_a = 1'b0;
            if (i == 11) init_a = 1'b1;
            if (i == 12) init_a = 1'b0;
        end
        bc = 0;
        for (int i = 0; i < 12; i++) bc += int'(oa[i][8]);
        total++;
        if (bc !== 10) $display("FAIL exp0_busy got %0d expected 10", bc);
        else passed++;
        k = 0;
        while (qa.size() > 0) begin
            ea = qa.pop_front(); eb = qb.pop_front();
            ga = oa.pop_front(); gb = ob.pop_front();
            total++;
            if (ga !== ea || gb !== eb)
                $display("FAIL back_to_back cyc%0d a=%b/%b b=%b/%b (got/exp)", k, ga, ea, gb, eb);
            else
                passed++;
            k++;
        end
    endtask

    // Abort lands while row 1 is converting (cycle 8 with ExpTime=3).
    task automatic test_abort();
        word_t ea, eb, ga, gb;
        int k, n;
        exp_a = 5'd3;
        init_a = 1'b1;
        push_frame(0, 3, 2, 1, 1, 9);
        pad_idle(2);
        push_frame(0, 2, 2, 1, 1, -1);
        pad_idle(2);
        pad();
        n = qa.size();
        for (int i = 0; i < n; i++) begin
            cycle();
            if (i == 0) init_a = 1'b0;
            if (i == 8) abort_a = 1'b1;
            if (i == 9) abort_a = 1'b0;
            if (i == 10) begin
                exp_a = 5'd2;
                init_a = 1'b1;
            end
            if (i == 11) init_a = 1'b0;
        end
        k = 0;
        while (qa.size() > 0) begin
            ea = qa.pop_front(); eb = qb.pop_front();
            ga = oa.pop_front(); gb = ob.pop_front();
            total++;
            if (ga !== ea || gb !== eb)
                $display("FAIL abort cyc%0d a=%b/%b b=%b/%b (got/exp)", k, ga, ea, gb, eb);
            else
                passed++;
            k++;
        end
    endtask

    task automatic test_retrigger();
        word_t ea, eb, ga, gb;
        int k, n, dc;
        exp_a = 5'd5;
        init_a = 1'b1;
        push_frame(0, 5, 2, 1, 1, -1);
        pad_idle(4);
        pad();
        n = qa.size();
        for (int i = 0; i < n; i++) begin
            cycle();
            if (i == 0) init_a = 1'b0;
            if (i == 1) init_a = 1'b1;
        end
        init_a = 1'b0;
        dc = 0;
        foreach (oa[i]) dc += int'(oa[i][7]);
        total++;
        if (dc !== 1) $display("FAIL retrigger_done got %0d expected 1", dc);
        else passed++;
        k = 0;
        while (qa.size() > 0) begin
            ea = qa.pop_front(); eb = qb.pop_front();
            ga = oa.pop_front(); gb = ob.pop_front();
            total++;
            if (ga !== ea || gb !== eb)
                $display("FAIL retrigger cyc%0d a=%b/%b b=%b/%b (got/exp)", k, ga, ea, gb, eb);
            else
                passed++;
            k++;
        end
    endtask

    task automatic test_abort_priority();
        word_t ea, eb, ga, gb;
        int k, n;
        exp_a = 5'd1;
        init_a = 1'b1;
        abort_a = 1'b1;
        pad_idle(3);
        push_frame(0, 1, 2, 1, 1, -1);
        pad_idle(1);
        pad();
        n = qa.size();
        for (int i = 0; i < n; i++) begin
            cycle();
            if (i == 0) abort_a = 1'b0;
            if (i == 1) init_a = 1'b0;
            if (i == 2) init_a = 1'b1;
            if (i == 3) init_a = 1'b0;
        end
        k = 0;
        while (qa.size() > 0) begin
            ea = qa.pop_front(); eb = qb.pop_front();
            ga = oa.pop_front(); gb = ob.pop_front();
            total++;
            if (ga !== ea || gb !== eb)
                $display("FAIL abort_prio cyc%0d a=%b/%b b=%b/%b (got/exp)", k, ga, ea, gb, eb);
            else
                passed++;
            k++;
        end
    endtask

    task automatic test_reset_mid();
        word_t ea, eb, ga, gb;
        int k, n;
        exp_a = 5'd10;
        init_a = 1'b1;
        push_frame(0, 10, 2, 1, 1, 3);
        pad_idle(6);
        pad();
        n = qa.size();
        for (int i = 0; i < n; i++) begin
            cycle();
            if (i == 0) init_a = 1'b0;
            if (i == 2) begin
                #2 Reset = 1'b1;
                #1;
                total++;
                if (word_a() !== IDLE_W)
                    $display("FAIL reset_mid_async got %b expected %b", word_a(), IDLE_W);
                else
                    passed++;
            end
            if (i == 4) Reset = 1'b0;
        end
        k = 0;
        while (qa.size() > 0) begin
            ea = qa.pop_front(); eb = qb.pop_front();
            ga = oa.pop_front(); gb = ob.pop_front();
            total++;
            if (ga !== ea || gb !== eb)
                $display("FAIL reset_mid cyc%0d a=%b/%b b=%b/%b (got/exp)", k, ga, ea, gb, eb);
            else
                passed++;
            k++;
        end
    endtask

    task automatic test_four_rows();
        word_t ea, eb, ga, gb;
        int k, n, bc, bad;
        exp_b = 5'd7;
        init_b = 1'b1;
        push_frame(1, 7, 4, 2, 3, -1);
        pad_idle(2);
        pad();
        n = qb.size();
        for (int i = 0; i < n; i++) begin
            cycle();
            if (i == 0) begin
                init_b = 1'b0;
                exp_b = 5'd1;
            end
        end
        bc = 0;
        bad = 0;
        foreach (ob[i]) begin
            bc += int'(ob[i][8]);
            if (!$onehot0(ob[i][5:2]) || (ob[i][6] && !$onehot(ob[i][5:2])))
                bad++;
        end
        total++;
        if (bc !== 36) $display("FAIL four_rows_busy got %0d expected 36", bc);
        else passed++;
        total++;
        if (bad !== 0) $display("FAIL four_rows_onehot got %0d bad cycles expected 0", bad);
        else passed++;
        k = 0;
        while (qb.size() > 0) begin
            ea = qa.pop_front(); eb = qb.pop_front();
            ga = oa.pop_front(); gb = ob.pop_front();
            total++;
            if (ga !== ea || gb !== eb)
                $display("FAIL four_rows cyc%0d a=%b/%b b=%b/%b (got/exp)", k, ga, ea, gb, eb);
            else
                passed++;
            k++;
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_back_to_back();
        test_abort();
        test_retrigger();
        test_abort_priority();
        test_reset_mid();
        test_four_rows();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pixel_readout_seq.md
PIXEL_READOUT_SEQ -- requirements
Module: pixel_readout_seq

Interface
REQ-001 Parameter N_ROWS, default 2: number of pixel rows read out per frame, range 1..16.
REQ-002 Parameter EXP_W, default 5: width of the exposure-time input and its internal counter.
REQ-003 Parameter SETTLE_CYC, default 1: number of cycles a row select is held before ADC assertion, range 1..15.
REQ-004 Parameter ADC_CYC, default 1: ADC pulse width in cycles, range 1..15.
REQ-005 Port Clk, input, 1 bit: clock; all state changes occur on its rising edge.
REQ-006 Port Reset, input, 1 bit: reset, asynchronous, active-high.
REQ-007 Port Init, input, 1 bit: frame start request, rising-edge detected.
REQ-008 Port ExpTime, input, EXP_W bits: exposure length in cycles, captured at frame start.
REQ-009 Port Abort, input, 1 bit: synchronous frame cancel.
REQ-010 Port Erase, output, 1 bit: pixel erase, high whenever no frame is in progress.
REQ-011 Port Expose, output, 1 bit: exposure window.
REQ-012 Port NRE, output, N_ROWS bits: one-hot row read enable, active-high.
REQ-013 Port ADC, output, 1 bit: ADC convert strobe.
REQ-014 Port RowIdx, output, max(1,clog2(N_ROWS)) bits: index of the row being read.
REQ-015 Port Busy, output, 1 bit: high in every state except IDLE.
REQ-016 Port Done, output, 1 bit: one-cycle frame-complete pulse.

Function
REQ-017 All outputs SHALL be registered, driven directly from flops.
REQ-018 The block SHALL implement states IDLE, EXPOSE, SEL, CONV, HOLD, DESEL and DONE.
REQ-019 A start SHALL be detected as Init=1 on the current edge with Init=0 on the previous edge; the previous-edge register SHALL reset to 0.
REQ-020 In IDLE, a start SHALL move to EXPOSE, set Expose=1 and Erase=0, and load the counter with ExpTime, treating ExpTime=0 as 1.
REQ-021 Expose SHALL remain high for exactly max(ExpTime,1) cycles, then the block SHALL enter SEL with RowIdx=0.
REQ-022 Changes on ExpTime after capture SHALL have no effect on the current frame.
REQ-023 In SEL, NRE[RowIdx]=1 and ADC=0 SHALL hold for SETTLE_CYC cycles, then the block SHALL enter CONV.
REQ-024 In CONV, NRE[RowIdx]=1 and ADC=1 SHALL hold for ADC_CYC cycles, then the block SHALL enter HOLD.
REQ-025 HOLD SHALL last 1 cycle with NRE[RowIdx]=1 and ADC=0, then the block SHALL enter DESEL.
REQ-026 DESEL SHALL last 1 cycle with NRE all zero; then, if RowIdx<N_ROWS-1, RowIdx SHALL increment and the block SHALL return to SEL, otherwise it SHALL enter DONE.
REQ-027 Each row SHALL therefore take SETTLE_CYC+ADC_CYC+2 cycles; at most one NRE bit SHALL be high at any time; ADC SHALL never be high unless exactly one NRE bit is high.
REQ-028 DONE SHALL last 1 cycle with Done=1 and Erase=1, then the block SHALL enter IDLE.
REQ-029 Busy for one frame SHALL equal max(ExpTime,1)+N_ROWS*(SETTLE_CYC+ADC_CYC+2)+1 cycles.
REQ-030 A start occurring while Busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-031 Abort=1 in any non-IDLE state SHALL move the block to IDLE on the next edge with all outputs at reset values and no Done pulse.
REQ-032 Abort SHALL take priority over a simultaneous start; Abort in IDLE SHALL have no effect.
REQ-033 Init held high across a frame SHALL NOT retrigger a new frame.

Reset
REQ-034 Reset=1 SHALL immediately force IDLE, Erase=1, Expose=0, NRE=0, ADC=0, RowIdx=0, Busy=0, Done=0 and clear the counters, independent of Clk.
REQ-035 On Reset release, the block SHALL remain in IDLE until a new start is detected.

Verification
REQ-036 Defaults, ExpTime=5, single Init pulse -> Expose high 5 cycles; NRE=01 for 3 cycles with ADC in the 2nd; 1 cycle idle; NRE=10 likewise; Done pulse; Busy 14 cycles total.
REQ-037 Defaults, ExpTime=0 -> Expose high 1 cycle; Busy 10 cycles.
REQ-038 Abort asserted during the CONV state of row 1 -> next edge IDLE, Erase=1, NRE=0, ADC=0, no Done; a new Init pulse then runs a full frame.
REQ-039 Second Init pulse during EXPOSE, and Init held high through DONE -> exactly one frame and one Done pulse.
REQ-040 Reset asserted mid-EXPOSE between clock edges -> outputs at reset values before the next edge; no activity after release without Init.
REQ-041 N_ROWS=4, ADC_CYC=3, SETTLE_CYC=2, ExpTime=7 -> RowIdx steps 0..3, each ADC pulse 3 cycles, one-hot NRE throughout, Busy 36 cycles.
